rib_arbiter: RTL and testbench
==============================

# rib_arbiter

- Registered round-robin arbiter with transaction locking and timeout for the four-master RIB bus.
- Replaces fixed-priority combinational grant selection. Its registered `grant_o`/`grant_valid_o` drive the RIB master/slave multiplexer select.
- Produces the core pipeline hold flag, per-master completion/error pulses and a bus-timeout indication.
- Sits between the masters (core LSU, core fetch, DMA-like peripheral, JTAG debug) and the RIB mux.

## Interface
- `PRIO_MASK`, 4'b1000: masters in this mask win over all round-robin masters; lowest index wins among them.
- `FETCH_MASTER`, 1: index of the instruction-fetch master; it is excluded from the hold flag.
- `TIMEOUT_CYCLES`, 16: busy cycles without `slave_ready_i` before the grant is forcibly released (≥2).
- `LOCK_BEATS`, 4: maximum consecutive beats one master may keep the bus via `lock_i` (≥1).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_i`  in  4  per-master access request; held high until ack/err.
- `lock_i`  in  4  per-master request to keep the grant after the current beat.
- `slave_ready_i`  in  1  addressed slave completes the granted access this cycle.
- `grant_o`  out  2  index of granted master (mux select).
- `grant_valid_o`  out  1  a grant is active.
- `ack_o`  out  4  one-hot, 1-cycle pulse: access of that master completed.
- `err_o`  out  4  one-hot, 1-cycle pulse: access of that master timed out.
- `hold_flag_o`  out  1  stall core pipeline.
- `timeout_o`  out  1  1-cycle pulse on any timeout (interrupt/debug).

## Operation
- States: IDLE, BUSY.
- Reset values: `grant_o`=0, `grant_valid_o`=0, `ack_o`=0, `err_o`=0, `timeout_o`=0; state=IDLE; rr pointer=3; timeout counter=0; beat counter=0. `hold_flag_o` follows its equation.
- **Winner pick** (combinational):
  - If `req_i & PRIO_MASK` ≠0, pick the lowest set index of that set.
  - Otherwise search the remaining requests starting at (ptr+1) mod 4, wrapping.
- **IDLE**: if any `req_i`, register the winner into `grant_o`, set `grant_valid_o`=1, clear both counters, and go to BUSY.
- **BUSY, granted master g**, evaluated in priority order:
  1. **Abort**: `req_i[g]`=0 → release without ack/err; ptr←g; re-pick among the other requests this cycle.
  2. **Complete**: `slave_ready_i`=1 → `ack_o[g]` pulses in the same cycle (combinational from state, not registered).
     - If `lock_i[g]`=1 and beat count+1 < `LOCK_BEATS`: keep g, increment beat count, clear timeout count.
     - Otherwise: ptr←g, then re-pick with g masked out. Grant the new winner in the next cycle (zero bubble). If none, go to IDLE.
  3. **Timeout**: counter reaches `TIMEOUT_CYCLES`-1 → `err_o[g]`, `timeout_o` pulse. Release as in non-locked completion.
  4. Otherwise increment the timeout counter.
- Masking g on re-pick applies to round-robin and priority masters alike. A priority master re-requesting after its own beat waits at most one grant.
- **Hold flag**: `hold_flag_o` = |(`req_i` & ~(1<<`FETCH_MASTER`)) | (`grant_valid_o` & `grant_o`≠`FETCH_MASTER`). Combinational.
- Counters saturate and never wrap. The pointer wraps 3→0.

## Timing
- Request to grant: 1 cycle from IDLE. Back-to-back handoff: 0 bubble cycles.
- Minimum beat: grant cycle N, `slave_ready_i` at N → `ack_o` at N.
- Timeout: err at the `TIMEOUT_CYCLES`-th BUSY cycle with no ready.
- `rst` asserted mid-transfer: all registers clear immediately (async). No ack/err is emitted for the aborted beat.
- `slave_ready_i` while IDLE is ignored.
- `lock_i` of a non-granted master is ignored.

## Structure
- `rib_pkg`: master index constants (`M_LSU`=0, `M_FETCH`=1, `M_DMA`=2, `M_JTAG`=3), state enum, 2-bit grant type.
- Sub-module `rib_rr_pick`: combinational (req, mask, prio_mask, ptr) → (index, valid). It is used for both the IDLE pick and the BUSY re-pick.

## Test plan
- **Single master**: `req_i`=0001 → `grant_o`=0 and valid next cycle; ready the same cycle → `ack_o`=0001; returns to IDLE.
- **Round robin**: `req_i`=0111 held, ready every cycle → grants 0,1,2,0,1,2 with no bubbles.
- **Priority override**: `req_i`=0110, then `req_i[3]` rises while 1 is granted → after ack of 1, grant 3. Then 2 if still requesting.
- **Lock**: `lock_i[0]`=1, `LOCK_BEATS`=4, `req_i`=0011, ready always → four acks to master 0, then grant 1.
- **Timeout**: grant 2, ready never → at cycle 16 `err_o`=0100 and `timeout_o`=1; next waiting master granted.
- **Async reset**: assert `rst`=0 mid-BUSY → `grant_valid_o`, `ack_o`, `err_o` are 0 immediately; after release, pick restarts from master 0.

Source files
------------

// File: rtl/rib_pkg.sv
// Shared types and constants for the four-master RIB bus arbiter.
package rib_pkg;

  typedef logic [1:0] grant_t;

  localparam grant_t M_LSU   = 2'd0;
  localparam grant_t M_FETCH = 2'd1;
  localparam grant_t M_DMA   = 2'd2;
  localparam grant_t M_JTAG  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rib_rr_pick.sv
// Winner selection: lowest-index priority master first, else round robin after ptr.
module rib_rr_pick
  import rib_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [3:0] prio_mask,
  input  grant_t     ptr,
  output grant_t     index,
  output logic       valid
);

  logic [3:0] cand;
  logic [3:0] prio_cand;
  grant_t     idx;

  always_comb begin
    cand      = req & ~mask;
    prio_cand = cand & prio_mask;
    valid     = |cand;
    index     = '0;
    idx       = '0;
    if (|prio_cand) begin
      for (int i = 3; i >= 0; i--) begin
        if (prio_cand[i]) index = grant_t'(i);
      end
    end else begin
      // offset 4 wraps back onto ptr itself, so it is searched last
      for (int k = 4; k >= 1; k--) begin
        idx = ptr + grant_t'(k);
        if (cand[idx]) index = idx;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Registered round-robin arbiter for the RIB bus with beat locking and slave timeout.
module rib_arbiter
  import rib_pkg::*;
#(
  parameter logic [3:0] PRIO_MASK      = 4'b1000,
  parameter int         FETCH_MASTER   = 1,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter int         LOCK_BEATS     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic [3:0] lock_i,
  input  logic       slave_ready_i,
  output grant_t     grant_o,
  output logic       grant_valid_o,
  output logic [3:0] ack_o,
  output logic [3:0] err_o,
  output logic       hold_flag_o,
  output logic       timeout_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = $clog2(LOCK_BEATS + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(LOCK_BEATS - 1);
  localparam logic [3:0]    FETCH_BIT = 4'b0001 << FETCH_MASTER;

  state_e        state_q;
  grant_t        ptr_q;
  logic [TW-1:0] to_cnt_q;
  logic [BW-1:0] beat_cnt_q;

  logic       busy;
  logic [3:0] grant_bit;
  logic       abort;
  logic       complete;
  logic       keep;
  logic       tmo;
  logic       release_g;
  grant_t     pick_idx;
  logic       pick_valid;

  assign busy      = (state_q == ST_BUSY);
  assign grant_bit = 4'b0001 << grant_o;
  assign abort     = busy & ~req_i[grant_o];
  assign complete  = busy & req_i[grant_o] & slave_ready_i;
  assign keep      = complete & lock_i[grant_o] & (beat_cnt_q < BEAT_LAST);
  assign tmo       = busy & req_i[grant_o] & ~slave_ready_i & (to_cnt_q == TO_LAST);
  assign release_g = abort | (complete & ~keep) | tmo;

  // in BUSY the current owner is masked and the search starts just after it
  rib_rr_pick u_pick (
    .req       (req_i),
    .mask      (busy ? grant_bit : 4'b0000),
    .prio_mask (PRIO_MASK),
    .ptr       (busy ? grant_o : ptr_q),
    .index     (pick_idx),
    .valid     (pick_valid)
  );

  assign ack_o       = complete ? grant_bit : 4'b0000;
  assign err_o       = tmo ? grant_bit : 4'b0000;
  assign timeout_o   = tmo;
  assign hold_flag_o = (|(req_i & ~FETCH_BIT)) |
                       (grant_valid_o & (grant_o != grant_t'(FETCH_MASTER)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      grant_o       <= '0;
      grant_valid_o <= 1'b0;
      ptr_q         <= 2'd3;
      to_cnt_q      <= '0;
      beat_cnt_q    <= '0;
    end else if (!busy) begin
      if (pick_valid) begin
        state_q       <= ST_BUSY;
        grant_o       <= pick_idx;
        grant_valid_o <= 1'b1;
        to_cnt_q      <= '0;
        beat_cnt_q    <= '0;
      end
    end else if (release_g) begin
      ptr_q      <= grant_o;
      to_cnt_q   <= '0;
      beat_cnt_q <= '0;
      if (pick_valid) begin
        grant_o <= pick_idx;
      end else begin
        state_q       <= ST_IDLE;
        grant_valid_o <= 1'b0;
      end
    end else if (keep) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
      to_cnt_q   <= '0;
    end else if (to_cnt_q != TO_LAST) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Table-driven, scoreboarded bench for rib_arbiter; one vector describes one bus cycle.
module tb_rib_arbiter;
  import rib_pkg::*;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] lock;
    logic       rdy;
    logic       gv;
    logic [1:0] g;
    logic [3:0] ack;
    logic [3:0] err;
    logic       tmo;
    logic       hold;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] lock = '0;
  logic       rdy = 1'b0;
  grant_t     grant;
  logic       grant_valid;
  logic [3:0] ack;
  logic [3:0] err;
  logic       hold;
  logic       tmo;

  int n_cmp = 0;
  int n_err = 0;

  vec_t tbl[$];
  vec_t sb[$];

  rib_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .lock_i        (lock),
    .slave_ready_i (rdy),
    .grant_o       (grant),
    .grant_valid_o (grant_valid),
    .ack_o         (ack),
    .err_o         (err),
    .hold_flag_o   (hold),
    .timeout_o     (tmo)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [3:0] r, input logic [3:0] l, input logic rd,
                             input logic gv, input logic [1:0] g, input logic [3:0] a,
                             input logic [3:0] e, input logic t, input logic h);
    vec_t x;
    x.req = r; x.lock = l; x.rdy = rd; x.gv = gv; x.g = g;
    x.ack = a; x.err = e; x.tmo = t; x.hold = h;
    return x;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name);
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    cmp({name, ".gv"},   {3'b0, grant_valid}, {3'b0, e.gv});
    if (e.gv) cmp({name, ".grant"}, {2'b0, grant}, {2'b0, e.g});
    cmp({name, ".ack"},  ack, e.ack);
    cmp({name, ".err"},  err, e.err);
    cmp({name, ".tmo"},  {3'b0, tmo}, {3'b0, e.tmo});
    cmp({name, ".hold"}, {3'b0, hold}, {3'b0, e.hold});
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      req  = tbl[i].req;
      lock = tbl[i].lock;
      rdy  = tbl[i].rdy;
      sb.push_back(tbl[i]);
      @(negedge clk);
      check_out($sformatf("%s[%0d]", name, i));
    end
    tbl.delete();
  endtask

  task automatic do_reset(input string name);
    req = '0; lock = '0; rdy = 1'b0; rst = 1'b0;
    @(negedge clk);
    cmp({name, ".rst_gv"},  {3'b0, grant_valid}, 4'b0);
    cmp({name, ".rst_ack"}, ack, 4'b0);
    cmp({name, ".rst_err"}, err, 4'b0);
    cmp({name, ".rst_tmo"}, {3'b0, tmo}, 4'b0);
    cmp({name, ".rst_hold"}, {3'b0, hold}, 4'b0);
    rst = 1'b1;
  endtask

  initial begin
    // single master: grant next cycle, ack same cycle as ready, back to idle
    do_reset("single");
    tbl.push_back(v(4'b0001, 4'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0001, 4'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0000, 4'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b0));
    run_table("single");

    // round robin 0,1,2,0,1,2 without bubbles; ready in IDLE ignored; abort releases
    do_reset("rr");
    tbl.push_back(v(4'b0111, 4'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0111, 4'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0111, 4'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0111, 4'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0111, 4'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0111, 4'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0111, 4'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0000, 4'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0000, 4'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b0));
    run_table("rr");

    // priority master 3 jumps the queue after master 1's beat, then 2
    do_reset("prio");
    tbl.push_back(v(4'b0110, 4'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b1110, 4'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b1110, 4'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b1100, 4'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0100, 4'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0000, 4'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b0));
    run_table("prio");

    // lock: four beats to master 0, then fetch master alone (hold drops)
    do_reset("lock");
    tbl.push_back(v(4'b0011, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b1));
    for (int b = 0; b < 4; b++)
      tbl.push_back(v(4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0010, 4'b0001, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0, 1'b0, 1'b0));
    tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b0));
    run_table("lock");

    // timeout: master 2 never served, err on the 16th busy cycle, master 0 next
    do_reset("timeout");
    tbl.push_back(v(4'b0100, 4'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b1));
    for (int k = 1; k <= 16; k++)
      tbl.push_back(v(4'b0101, 4'b0, 1'b0, 1'b1, 2'd2, 4'b0000,
                      (k == 16) ? 4'b0100 : 4'b0000, (k == 16), 1'b1));
    tbl.push_back(v(4'b0001, 4'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0000, 4'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b0));
    run_table("timeout");

    // async reset mid-beat, then the pointer restarts at master 0
    do_reset("areset");
    tbl.push_back(v(4'b0011, 4'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0, 1'b0, 1'b1));
    tbl.push_back(v(4'b0011, 4'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0, 1'b0, 1'b1));
    run_table("areset");
    @(posedge clk); #1;
    req = 4'b0010; rdy = 1'b1;
    #2;
    cmp("areset.pre_gv",    {3'b0, grant_valid}, 4'b0001);
    cmp("areset.pre_grant", {2'b0, grant}, 4'b0001);
    cmp("areset.pre_ack",   ack, 4'b0010);
    rst = 1'b0;
    #1;
    cmp("areset.gv",  {3'b0, grant_valid}, 4'b0);
    cmp("areset.ack", ack, 4'b0);
    cmp("areset.err", err, 4'b0);
    cmp("areset.tmo", {3'b0, tmo}, 4'b0);
    @(posedge clk); #1;
    cmp("areset.held_gv", {3'b0, grant_valid}, 4'b0);
    req = 4'b0011; rdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    cmp("areset.restart_gv",    {3'b0, grant_valid}, 4'b0001);
    cmp("areset.restart_grant", {2'b0, grant}, 4'b0000);
    req = 4'b0000;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
